// File: rtl/code_entry_ctrl.sv
// Keypad digit-entry sequencer: debounces the encoder output, writes each accepted
// digit into the next of four shift-register slots, and handles enter/clear/full.
module code_entry_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] key_code,
  input  logic       enter,
  input  logic       clear_req,
  output logic [3:0] load_en,
  output logic [1:0] reg_mode,
  output logic [3:0] reg_data,
  output logic       reg_clear,
  output logic [2:0] digit_count,
  output logic       full,
  output logic       code_ready,
  output logic       entry_err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_WRITE,
    ST_RELEASE,
    ST_FULL,
    ST_COMMIT
  } state_e;

  localparam logic [3:0] DB_LAST    = 4'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0] MAX_DIGITS = 3'd4;

  state_e     state_q, state_d;
  logic [3:0] db_cnt_q, db_cnt_d;
  logic [3:0] cand_q, cand_d;
  logic [2:0] count_q, count_d;
  logic       key_prev_q, key_prev_d;
  logic       enter_prev_q, enter_prev_d;
  logic       err_q, err_d;
  logic       clr_pulse_q, clr_pulse_d;

  logic       key_valid;
  logic [3:0] key_digit;

  assign key_valid = key_code[4];
  assign key_digit = key_code[3:0];

  // NOTE: every _d gets a default before any branch, so no path leaves a latch behind.
  always_comb begin
    state_d      = state_q;
    db_cnt_d     = db_cnt_q;
    cand_d       = cand_q;
    count_d      = count_q;
    err_d        = 1'b0;
    clr_pulse_d  = 1'b0;
    key_prev_d   = key_valid;
    enter_prev_d = enter;

    if (clear_req) begin
      // Clear outranks everything; a still-held key must be released before it counts again.
      clr_pulse_d = 1'b1;
      count_d     = '0;
      db_cnt_d    = '0;
      state_d     = key_valid ? ST_RELEASE : ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (enter) begin
            if (!enter_prev_q && (count_q < MAX_DIGITS)) err_d = 1'b1;
          end else if (key_valid) begin
            cand_d   = key_digit;
            db_cnt_d = 4'd1;
            state_d  = ST_DEBOUNCE;
          end
        end

        ST_DEBOUNCE: begin
          if (key_valid && (key_digit == cand_q)) begin
            if (db_cnt_q == DB_LAST) state_d = ST_WRITE;
            else                     db_cnt_d = db_cnt_q + 4'd1;
          end else begin
            db_cnt_d = '0;
            state_d  = ST_IDLE;
          end
        end

        ST_WRITE: begin
          count_d  = count_q + 3'd1;
          db_cnt_d = '0;
          state_d  = ST_RELEASE;
        end

        ST_RELEASE: begin
          if (!key_valid) state_d = (count_q == MAX_DIGITS) ? ST_FULL : ST_IDLE;
        end

        ST_FULL: begin
          if (enter)                         state_d = ST_COMMIT;
          else if (key_valid && !key_prev_q) err_d   = 1'b1;
        end

        ST_COMMIT: begin
          count_d = '0;
          state_d = ST_IDLE;
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: only a handful of control flops here, so all of them take the reset value.
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      db_cnt_q     <= '0;
      cand_q       <= '0;
      count_q      <= '0;
      key_prev_q   <= 1'b0;
      enter_prev_q <= 1'b0;
      err_q        <= 1'b0;
      clr_pulse_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      db_cnt_q     <= db_cnt_d;
      cand_q       <= cand_d;
      count_q      <= count_d;
      key_prev_q   <= key_prev_d;
      enter_prev_q <= enter_prev_d;
      err_q        <= err_d;
      clr_pulse_q  <= clr_pulse_d;
    end
  end

  // Outputs decode registered state only; WRITE is only reachable with count_q < 4.
  always_comb begin
    load_en  = '0;
    reg_data = '0;
    if (state_q == ST_WRITE) begin
      load_en  = 4'b0001 << count_q[1:0];
      reg_data = cand_q;
    end
    reg_mode    = (load_en != '0) ? 2'b11 : 2'b00;
    reg_clear   = clr_pulse_q || (state_q == ST_COMMIT);
    code_ready  = (state_q == ST_COMMIT);
    entry_err   = err_q;
    digit_count = count_q;
    full        = (count_q == MAX_DIGITS);
  end

  a_load_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(load_en));
  a_load_excl_clear: assert property (@(posedge clk) disable iff (!rst_n)
    !((load_en != '0) && reg_clear));
  a_mode_with_load: assert property (@(posedge clk) disable iff (!rst_n)
    ((reg_mode == 2'b11) == (load_en != '0)));

endmodule

// File: tb/tb_code_entry_ctrl.sv
// Bench for code_entry_ctrl: directed scenarios then random transactions, each
// expected output derived per cycle from a transaction-level model of the digit count.
module tb_code_entry_ctrl;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] key_code;
  logic       enter;
  logic       clear_req;
  logic [3:0] load_en;
  logic [1:0] reg_mode;
  logic [3:0] reg_data;
  logic       reg_clear;
  logic [2:0] digit_count;
  logic       full;
  logic       code_ready;
  logic       entry_err;

  int n_checks = 0;
  int n_pass   = 0;
  int c        = 0;  // digits the model believes are stored

  code_entry_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_code   (key_code),
    .enter      (enter),
    .clear_req  (clear_req),
    .load_en    (load_en),
    .reg_mode   (reg_mode),
    .reg_data   (reg_data),
    .reg_clear  (reg_clear),
    .digit_count(digit_count),
    .full       (full),
    .code_ready (code_ready),
    .entry_err  (entry_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
  endtask

  // Apply inputs for one edge, then compare every output half a cycle later.
  task automatic step(input logic [4:0] kc, input logic en, input logic clr, input logic rn,
                      input logic [3:0] x_load, input logic [3:0] x_data, input logic [2:0] x_cnt,
                      input logic x_err, input logic x_rdy, input logic x_clr);
    key_code  = kc;
    enter     = en;
    clear_req = clr;
    rst_n     = rn;
    @(posedge clk);
    @(negedge clk);
    check("load_en",     8'(load_en),     8'(x_load));
    check("reg_mode",    8'(reg_mode),    (x_load != 4'd0) ? 8'h03 : 8'h00);
    check("reg_data",    8'(reg_data),    8'(x_data));
    check("reg_clear",   8'(reg_clear),   8'(x_clr));
    check("digit_count", 8'(digit_count), 8'(x_cnt));
    check("full",        8'(full),        (x_cnt == 3'd4) ? 8'h01 : 8'h00);
    check("code_ready",  8'(code_ready),  8'(x_rdy));
    check("entry_err",   8'(entry_err),   8'(x_err));
  endtask

  // Key held for 'hold' edges then released: writes slot c at edge D-1 if long enough and not full.
  task automatic do_press(input logic [3:0] d, input int hold, input int gap);
    bit wr;
    bit at_w;
    wr = (c < 4) && (hold >= D);
    for (int k = 0; k < hold + gap; k++) begin
      at_w = wr && (k == D - 1);
      step((k < hold) ? {1'b1, d} : 5'd0, 1'b0, 1'b0, 1'b1,
           at_w ? 4'(1 << c) : 4'd0, at_w ? d : 4'd0,
           3'(c + ((wr && k >= D) ? 1 : 0)),
           (c == 4) && (k == 0), 1'b0, 1'b0);
    end
    if (wr) c++;
  endtask

  // Digit d1 for n1 < D edges, then d2 for n2 <= D edges: never long enough to write.
  task automatic do_bounce(input logic [3:0] d1, input int n1, input logic [3:0] d2,
                           input int n2, input int gap);
    logic [4:0] kc;
    for (int k = 0; k < n1 + n2 + gap; k++) begin
      if (k < n1)           kc = {1'b1, d1};
      else if (k < n1 + n2) kc = {1'b1, d2};
      else                  kc = 5'd0;
      step(kc, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 3'(c), (c == 4) && (k == 0), 1'b0, 1'b0);
    end
  endtask

  // enter held for 'hold' edges: commit when four digits are stored, otherwise one error.
  task automatic do_enter(input int hold, input int gap);
    bit commit;
    commit = (c == 4);
    for (int k = 0; k < hold + gap; k++) begin
      step(5'd0, k < hold, 1'b0, 1'b1, 4'd0, 4'd0,
           (commit && k >= 1) ? 3'd0 : 3'(c),
           !commit && (k == 0), commit && (k == 0), commit && (k == 0));
    end
    if (commit) c = 0;
  endtask

  // Key held for 'hold' edges (0 = no key), clear at edge cl (cl < D, and cl < hold when keyed).
  task automatic do_clear(input logic [3:0] d, input int hold, input int cl, input int gap);
    int total;
    total = ((hold > cl) ? hold : cl + 1) + gap;
    for (int k = 0; k < total; k++) begin
      step((k < hold) ? {1'b1, d} : 5'd0, 1'b0, k == cl, 1'b1, 4'd0, 4'd0,
           (k < cl) ? 3'(c) : 3'd0,
           (c == 4) && (hold > 0) && (cl > 0) && (k == 0), 1'b0, k == cl);
    end
    c = 0;
  endtask

  // Stable press reaching WRITE, reset sampled on the edge that would leave WRITE.
  task automatic do_reset_write(input logic [3:0] d, input int gap);
    for (int k = 0; k < D; k++) begin
      step({1'b1, d}, 1'b0, 1'b0, 1'b1,
           (k == D - 1) ? 4'(1 << c) : 4'd0, (k == D - 1) ? d : 4'd0,
           3'(c), 1'b0, 1'b0, 1'b0);
    end
    step(5'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    c = 0;
    for (int k = 0; k < gap; k++) begin
      step(5'd0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int         op;
    int         gap;
    int         cl;
    int         hold;
    logic [3:0] d;
    logic [3:0] d2;

    key_code  = 5'd0;
    enter     = 1'b0;
    clear_req = 1'b0;
    rst_n     = 1'b0;

    step(5'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    step(5'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0);

    do_press(4'h5, 6, 3);
    do_clear(4'h0, 0, 0, 2);
    do_bounce(4'h7, 2, 4'h3, 1, 3);

    for (int i = 1; i <= 4; i++) do_press(4'(i), D + 1, 2);
    do_press(4'h9, D + 2, 2);
    do_enter(1, 3);

    do_press(4'h1, D, 2);
    do_press(4'h2, D, 2);
    do_enter(2, 3);
    do_clear(4'h6, 10, 2, 2);
    do_press(4'h6, D, 2);
    do_press(4'h7, D, 2);
    do_reset_write(4'h8, 3);
    do_press(4'h0, D, 2);

    for (int i = 0; i < 80; i++) begin
      op  = $urandom_range(0, 9);
      d   = 4'($urandom_range(0, 9));
      gap = $urandom_range(2, 4);
      case (op)
        0, 1, 2, 3, 4: do_press(d, $urandom_range(D, D + 4), gap);
        5: do_press(d, $urandom_range(1, D - 1), gap);
        6: begin
          d2 = 4'((int'(d) + 1 + $urandom_range(0, 7)) % 10);
          do_bounce(d, $urandom_range(1, D - 1), d2, $urandom_range(1, D), gap);
        end
        7: do_enter($urandom_range(1, 3), gap);
        8: begin
          cl   = $urandom_range(0, D - 1);
          hold = ($urandom_range(0, 1) == 0) ? 0 : cl + $urandom_range(1, 6);
          do_clear(d, hold, cl, gap);
        end
        default: begin
          if (c < 4) do_reset_write(d, gap);
          else       do_enter(1, gap);
        end
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
